// File: rtl/trigger_capture_pkg.sv
// Shared definitions for the logic-analyzer capture front end: default sizes and FSM state encoding.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif
`ifndef MEMORY_SIZE
`define MEMORY_SIZE 16
`endif

package trigger_capture_pkg;

    localparam int DEF_DATA_WIDTH  = `DATA_WIDTH;
    localparam int DEF_ADDR_WIDTH  = `ADDR_WIDTH;
    localparam int DEF_MEMORY_SIZE = `MEMORY_SIZE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        POST = 2'd2,
        DUMP = 2'd3
    } state_t;

endpackage

// File: rtl/trigger_capture_trig_match.sv
// Masked equality trigger: hit when every bit selected by trig_mask matches trig_value.
// Kept separate so edge or sequence triggers can be dropped in later.
module trigger_capture_trig_match #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] sample,
    input  logic [DATA_WIDTH-1:0] trig_value,
    input  logic [DATA_WIDTH-1:0] trig_mask,
    output logic                  hit
);

    assign hit = ((sample ^ trig_value) & trig_mask) == '0;

endmodule

// File: rtl/trigger_capture.sv
// Capture front end: fills the circular sample buffer, waits for the trigger, stores the
// post-trigger samples, then strobes the readout stage through exactly one buffer's worth of reads.
module trigger_capture
    import trigger_capture_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int MEMORY_SIZE = DEF_MEMORY_SIZE,
    parameter int POST_TRIG   = MEMORY_SIZE / 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  arm,
    input  logic [DATA_WIDTH-1:0] sample,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] trig_value,
    input  logic [DATA_WIDTH-1:0] trig_mask,
    input  logic                  dump_stall,
    output logic [DATA_WIDTH-1:0] memory [0:MEMORY_SIZE-1],
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic                  read_enable,
    output logic                  busy,
    output logic                  triggered,
    output logic                  capture_done
);

    localparam logic [ADDR_WIDTH:0]   PRE_CNT   = (ADDR_WIDTH+1)'(MEMORY_SIZE - 1 - POST_TRIG);
    localparam logic [ADDR_WIDTH:0]   POST_LAST = (ADDR_WIDTH+1)'((POST_TRIG > 0) ? POST_TRIG - 1 : 0);
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(MEMORY_SIZE);
    localparam logic [ADDR_WIDTH:0]   LAST_RD   = (ADDR_WIDTH+1)'(MEMORY_SIZE - 1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    state_t                state;
    logic [ADDR_WIDTH:0]   fill_cnt;
    logic [ADDR_WIDTH:0]   post_cnt;
    logic [ADDR_WIDTH:0]   rd_cnt;
    logic [ADDR_WIDTH-1:0] next_waddr;
    logic                  write_en;
    logic                  hit;

    trigger_capture_trig_match #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_trig_match (
        .sample    (sample),
        .trig_value(trig_value),
        .trig_mask (trig_mask),
        .hit       (hit)
    );

    assign next_waddr = waddr + ADDR_ONE;
    assign write_en   = sample_valid && (state == FILL || state == POST);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (write_en)
            memory[next_waddr] <= sample;
    end

    // waddr always names the newest stored sample, so readout starts at waddr+1 (the oldest).
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            waddr        <= '1;
            fill_cnt     <= '0;
            post_cnt     <= '0;
            rd_cnt       <= '0;
            read_enable  <= 1'b0;
            triggered    <= 1'b0;
            capture_done <= 1'b0;
        end else begin
            capture_done <= 1'b0;
            if (write_en)
                waddr <= next_waddr;

            case (state)
                IDLE: begin
                    if (arm) begin
                        state    <= FILL;
                        waddr    <= '1;
                        fill_cnt <= '0;
                    end
                end
                FILL: begin
                    if (sample_valid) begin
                        if (fill_cnt >= PRE_CNT && hit) begin
                            triggered <= 1'b1;
                            post_cnt  <= '0;
                            if (POST_TRIG == 0) begin
                                state       <= DUMP;
                                rd_cnt      <= '0;
                                read_enable <= 1'b0;
                            end else begin
                                state <= POST;
                            end
                        end else if (fill_cnt < PRE_CNT) begin
                            fill_cnt <= fill_cnt + CNT_ONE;
                        end
                    end
                end
                POST: begin
                    if (sample_valid) begin
                        if (post_cnt == POST_LAST) begin
                            state       <= DUMP;
                            rd_cnt      <= '0;
                            read_enable <= 1'b0;
                        end else begin
                            post_cnt <= post_cnt + CNT_ONE;
                        end
                    end
                end
                DUMP: begin
                    // capture_done is held while still in DUMP so a coincident arm is ignored.
                    if (rd_cnt == DEPTH_CNT) begin
                        state       <= IDLE;
                        triggered   <= 1'b0;
                        read_enable <= 1'b0;
                        rd_cnt      <= '0;
                    end else if (read_enable && rd_cnt == LAST_RD) begin
                        rd_cnt       <= DEPTH_CNT;
                        read_enable  <= 1'b0;
                        capture_done <= 1'b1;
                    end else begin
                        if (read_enable)
                            rd_cnt <= rd_cnt + CNT_ONE;
                        read_enable <= !dump_stall;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trigger_capture.sv
// Randomized self-checking bench for trigger_capture; a sample-index model predicts buffer
// contents, trigger position and hand-off address for each capture.
module tb_trigger_capture;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int MS = 16;
    localparam int PT = 4;

    logic          clk = 1'b0;
    logic          reset, arm, sample_valid, dump_stall;
    logic [DW-1:0] sample, trig_value, trig_mask;
    logic [DW-1:0] memory0 [0:MS-1];
    logic [DW-1:0] memory1 [0:MS-1];
    logic [AW-1:0] waddr0, waddr1;
    logic          re0, re1, busy0, busy1, trig0, trig1, done0, done1;
    logic          sel = 1'b0;

    logic [AW-1:0] o_waddr;
    logic          o_re, o_busy, o_trig, o_done;

    int compared = 0;
    int mismatched = 0;

    logic [DW-1:0] m_mem [0:MS-1];
    int            n_wr, trig_idx, m_post, m_pre;
    bit            m_active;

    always #5 clk = ~clk;

    trigger_capture #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEMORY_SIZE(MS), .POST_TRIG(PT)
    ) dut0 (
        .clk(clk), .reset(reset), .arm(arm), .sample(sample), .sample_valid(sample_valid),
        .trig_value(trig_value), .trig_mask(trig_mask), .dump_stall(dump_stall),
        .memory(memory0), .waddr(waddr0), .read_enable(re0), .busy(busy0),
        .triggered(trig0), .capture_done(done0)
    );

    trigger_capture #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEMORY_SIZE(MS), .POST_TRIG(0)
    ) dut1 (
        .clk(clk), .reset(reset), .arm(arm), .sample(sample), .sample_valid(sample_valid),
        .trig_value(trig_value), .trig_mask(trig_mask), .dump_stall(dump_stall),
        .memory(memory1), .waddr(waddr1), .read_enable(re1), .busy(busy1),
        .triggered(trig1), .capture_done(done1)
    );

    assign o_waddr = sel ? waddr1 : waddr0;
    assign o_re    = sel ? re1    : re0;
    assign o_busy  = sel ? busy1  : busy0;
    assign o_trig  = sel ? trig1  : trig0;
    assign o_done  = sel ? done1  : done0;

    function automatic logic [DW-1:0] mem_at(input int a);
        return sel ? memory1[a] : memory0[a];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic a, input logic v, input logic st, input logic [DW-1:0] s);
        arm          = a;
        sample_valid = v;
        dump_stall   = st;
        sample       = s;
    endtask

    task automatic reset_all();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        tick();
        tick();
        checkOutput("rst.busy0", busy0, 0);
        checkOutput("rst.busy1", busy1, 0);
        checkOutput("rst.waddr0", waddr0, MS - 1);
        checkOutput("rst.waddr1", waddr1, MS - 1);
        checkOutput("rst.flags0", {trig0, re0, done0}, 0);
        checkOutput("rst.flags1", {trig1, re1, done1}, 0);
        reset = 1'b0;
    endtask

    task automatic check_buffer(input string name);
        for (int a = 0; a < MS; a++)
            checkOutput($sformatf("%s.mem[%0d]", name, a), mem_at(a), m_mem[a]);
    endtask

    // vmode: 0 always valid, 1 alternate, 2 random; smode: 0 counting, 1 random;
    // stmode: 0 no stall, 1 five stalls after third read, 2 random.
    task automatic run_capture(input string name, input logic use1,
                               input logic [DW-1:0] tv_a, input logic [DW-1:0] tm,
                               input int switch_at, input logic [DW-1:0] tv_b,
                               input int vmode, input int smode, input int stmode,
                               input int abort_post, input int exp_waddr);
        int            seq, cyc, reads, stall_left, last_w;
        bit            stall_used, done_seen;
        logic          v, st, a;
        logic [DW-1:0] s;

        sel        = use1;
        m_post     = use1 ? 0 : PT;
        m_pre      = MS - 1 - m_post;
        trig_value = tv_a;
        trig_mask  = tm;

        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        tick();
        checkOutput({name, ".armed_busy"}, o_busy, 1);
        checkOutput({name, ".armed_waddr"}, o_waddr, MS - 1);

        n_wr = 0; trig_idx = -1; m_active = 1; seq = 0; cyc = 0;
        while (m_active && cyc < 3000) begin
            if (switch_at >= 0 && seq == switch_at)
                trig_value = tv_b;
            v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            s = (smode == 0) ? DW'(seq) : DW'($urandom);
            a = ($urandom_range(0, 7) == 0);
            applyStimulus(a, v, 1'b0, s);
            if (v) begin
                m_mem[n_wr % MS] = s;
                if (trig_idx < 0 && n_wr >= m_pre && ((s ^ trig_value) & tm) == 0)
                    trig_idx = n_wr;
                if (trig_idx >= 0 && n_wr == trig_idx + m_post)
                    m_active = 0;
                n_wr++;
                seq++;
            end
            tick();
            cyc++;
            checkOutput({name, ".waddr"}, o_waddr, (n_wr + MS - 1) % MS);
            checkOutput({name, ".triggered"}, o_trig, trig_idx >= 0);
            checkOutput({name, ".busy"}, o_busy, 1);
            checkOutput({name, ".re_idle"}, {o_re, o_done}, 0);

            if (abort_post >= 0 && trig_idx >= 0 && n_wr == trig_idx + 1 + abort_post) begin
                reset = 1'b1;
                applyStimulus(1'b1, 1'b0, 1'b0, '0);
                tick();
                reset = 1'b0;
                applyStimulus(1'b0, 1'b0, 1'b0, '0);
                checkOutput({name, ".abort_busy"}, o_busy, 0);
                checkOutput({name, ".abort_trig"}, o_trig, 0);
                checkOutput({name, ".abort_waddr"}, o_waddr, MS - 1);
                checkOutput({name, ".abort_re"}, {o_re, o_done}, 0);
                return;
            end
        end
        checkOutput({name, ".capture_ends"}, m_active, 0);
        if (m_active) begin
            reset_all();
            return;
        end

        last_w = (n_wr - 1) % MS;
        check_buffer({name, ".handoff"});
        if (exp_waddr >= 0)
            checkOutput({name, ".handoff_waddr"}, o_waddr, exp_waddr);

        reads = 0; stall_left = 0; stall_used = 0; done_seen = 0;
        for (int c = 0; c < 400 && !done_seen; c++) begin
            st = 1'b0;
            if (stmode == 1) begin
                if (reads == 3 && !stall_used) begin
                    stall_left = 5;
                    stall_used = 1;
                end
                st = (stall_left > 0);
                if (stall_left > 0)
                    stall_left--;
            end else if (stmode == 2) begin
                st = ($urandom_range(0, 3) == 0);
            end
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), st, DW'($urandom));
            tick();
            if (o_re)
                reads++;
            if (st)
                checkOutput({name, ".re_stalled"}, o_re, 0);
            checkOutput({name, ".dump_waddr"}, o_waddr, last_w);
            if (o_done) begin
                done_seen = 1;
                checkOutput({name, ".reads_at_done"}, reads, MS);
                checkOutput({name, ".done_busy"}, o_busy, 1);
                checkOutput({name, ".done_trig"}, o_trig, 1);
                checkOutput({name, ".done_re"}, o_re, 0);
            end
        end
        checkOutput({name, ".done_seen"}, done_seen, 1);

        applyStimulus(1'b1, 1'b1, 1'b0, DW'($urandom));
        tick();
        checkOutput({name, ".post_busy"}, o_busy, 0);
        checkOutput({name, ".post_flags"}, {o_trig, o_re, o_done}, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, DW'($urandom));
        tick();
        checkOutput({name, ".arm_ignored"}, o_busy, 0);
        check_buffer({name, ".after_dump"});
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        reset = 1'b1;
        trig_value = '0;
        trig_mask = '0;
        applyStimulus(1'b0, 1'b0, 1'b0, '0);

        reset_all();
        run_capture("s1", 1'b0, 8'd20, 8'hFF, -1, 8'd0, 0, 0, 0, -1, 8);
        reset_all();
        run_capture("s2", 1'b0, 8'd3, 8'hFF, 20, 8'd30, 0, 0, 0, -1, 2);
        reset_all();
        run_capture("s3", 1'b0, 8'd20, 8'hFF, -1, 8'd0, 1, 0, 0, -1, 8);
        reset_all();
        run_capture("s4", 1'b0, 8'd20, 8'hFF, -1, 8'd0, 0, 0, 1, -1, 8);
        reset_all();
        run_capture("s5", 1'b0, 8'd20, 8'hFF, -1, 8'd0, 0, 0, 0, 2, -1);
        run_capture("s5b", 1'b0, 8'd20, 8'hFF, -1, 8'd0, 0, 0, 0, -1, 8);
        reset_all();
        run_capture("s6", 1'b1, 8'd0, 8'h00, -1, 8'd0, 0, 0, 0, -1, 15);

        for (int i = 0; i < 8; i++) begin
            int            b1, b2;
            logic [DW-1:0] tm;
            b1 = $urandom_range(0, DW - 1);
            b2 = $urandom_range(0, DW - 1);
            tm = (DW'(1) << b1) | (DW'(1) << b2);
            reset_all();
            run_capture($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), DW'($urandom), tm,
                        -1, 8'd0, 2, 1, 2, -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
